// File: rtl/bcd_hms_counter.sv
// bcd_hms_counter: six-digit BCD time-of-day counter (hh:mm:ss).
// Advances on a one-cycle `increase` tick and supports 12/24-hour display,
// validated parallel load, minute/hour set buttons and a day rollover pulse.
// Optional alarm compare is built when BCD_HMS_ALARM_EN is defined; without
// it, alarm is tied low and alarm_set is ignored (ports are identical).
// Hour register holds the displayed BCD hour: 00-23, or 01-12 with pm.
module bcd_hms_counter #(
    parameter int HOUR_MODE = 24,
    parameter bit RST_PM    = 1'b0
) (
    input  logic        clk_out,
    input  logic        rst,
    input  logic        increase,
    input  logic        load,
    input  logic [23:0] load_value,
    input  logic        load_pm,
    input  logic        inc_min,
    input  logic        inc_hour,
    input  logic        alarm_set,
    output logic [23:0] value,
    output logic        pm,
    output logic        day_over,
    output logic        load_err,
    output logic        alarm
);

    localparam bit         MODE12     = (HOUR_MODE == 12);
    localparam logic [7:0] RST_HOUR   = MODE12 ? 8'h12 : 8'h00;
    localparam logic       RST_PM_EFF = MODE12 ? RST_PM : 1'b0;

    generate
        if (HOUR_MODE != 12 && HOUR_MODE != 24) begin : g_bad_mode
            $error("bcd_hms_counter: HOUR_MODE must be 12 or 24");
        end
    endgenerate

    // Two-digit 00-59 step; MSB of the result is the carry out of the field.
    function automatic logic [8:0] step_60(input logic [7:0] v);
        logic [8:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = {1'b1, 8'h00};
            else                r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Hour step that wraps within the field (23->00 or 12->01).
    function automatic logic [7:0] step_hour(input logic [7:0] h);
        logic [7:0] r;
        if (MODE12 && h == 8'h12)       r = 8'h01;
        else if (!MODE12 && h == 8'h23) r = 8'h00;
        else if (h[3:0] == 4'd9)        r = {h[7:4] + 4'd1, 4'd0};
        else                            r = {h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    // True when a packed hh:mm:ss word is a legal time for this hour mode.
    function automatic logic time_ok(input logic [23:0] v);
        logic ok;
        ok = (v[23:20] <= 4'd9) && (v[19:16] <= 4'd9) &&
             (v[15:12] <= 4'd5) && (v[11:8]  <= 4'd9) &&
             (v[7:4]   <= 4'd5) && (v[3:0]   <= 4'd9);
        if (MODE12)
            ok = ok && ((v[23:20] == 4'd0 && v[19:16] != 4'd0) ||
                        (v[23:20] == 4'd1 && v[19:16] <= 4'd2));
        else
            ok = ok && ((v[23:20] <= 4'd1) ||
                        (v[23:20] == 4'd2 && v[19:16] <= 4'd3));
        return ok;
    endfunction

    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q,  min_d;
    logic [7:0] sec_q,  sec_d;
    logic       pm_q,   pm_d;
    logic       day_over_q, day_over_d;
    logic       load_err_q, load_err_d;
    logic       alarm_q,    alarm_d;

    logic       load_ok;
    logic       sec_carry, min_carry;
    logic [7:0] sec_next, min_next, hour_next;

`ifdef BCD_HMS_ALARM_EN
    logic [7:0] alarm_hour_q, alarm_hour_d;
    logic [7:0] alarm_min_q,  alarm_min_d;
    logic       alarm_pm_q,   alarm_pm_d;
`else
    logic       unused_alarm_set;
    assign unused_alarm_set = alarm_set;
`endif

    // Next-state: load beats set buttons, which beat the seconds tick.
    always_comb begin
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        pm_d       = pm_q;
        day_over_d = 1'b0;
        load_err_d = 1'b0;
        alarm_d    = 1'b0;
        load_ok    = time_ok(load_value);
        {sec_carry, sec_next} = step_60(sec_q);
        {min_carry, min_next} = step_60(min_q);
        hour_next  = step_hour(hour_q);
`ifdef BCD_HMS_ALARM_EN
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_pm_d   = alarm_pm_q;
`endif
        if (load) begin
            if (load_ok) begin
                {hour_d, min_d, sec_d} = load_value;
                pm_d = MODE12 ? load_pm : 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_hour || inc_min) begin
            if (inc_min)  min_d  = min_next;
            if (inc_hour) hour_d = hour_next;
        end else if (increase) begin
            sec_d = sec_next;
            if (sec_carry) begin
                min_d = min_next;
                if (min_carry) begin
                    hour_d = hour_next;
                    if (MODE12) begin
                        // 11:59:59 -> 12:00:00 flips AM/PM; only PM->AM ends the day
                        if (hour_q == 8'h11) begin
                            pm_d       = ~pm_q;
                            day_over_d = pm_q;
                        end
                    end else if (hour_q == 8'h23) begin
                        day_over_d = 1'b1;
                    end
                end
            end
`ifdef BCD_HMS_ALARM_EN
            alarm_d = ({hour_d, min_d, sec_d} == {alarm_hour_q, alarm_min_q, 8'h00}) &&
                      (pm_d == alarm_pm_q);
`endif
        end
`ifdef BCD_HMS_ALARM_EN
        if (alarm_set) begin
            if (load_ok) begin
                alarm_hour_d = load_value[23:16];
                alarm_min_d  = load_value[15:8];
                alarm_pm_d   = MODE12 ? load_pm : 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end
`endif
    end

    // State and registered output flags.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            hour_q     <= RST_HOUR;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            pm_q       <= RST_PM_EFF;
            day_over_q <= 1'b0;
            load_err_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            pm_q       <= pm_d;
            day_over_q <= day_over_d;
            load_err_q <= load_err_d;
            alarm_q    <= alarm_d;
        end
    end

`ifdef BCD_HMS_ALARM_EN
    // Alarm time registers, starting at the reset time.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            alarm_hour_q <= RST_HOUR;
            alarm_min_q  <= 8'h00;
            alarm_pm_q   <= RST_PM_EFF;
        end else begin
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_pm_q   <= alarm_pm_d;
        end
    end
`endif

    assign value    = {hour_q, min_q, sec_q};
    assign pm       = pm_q;
    assign day_over = day_over_q;
    assign load_err = load_err_q;
    assign alarm    = alarm_q;

endmodule

// File: doc/bcd_hms_counter.md
Name: bcd_hms_counter

Overview:
- Time-of-day counter for the wall-clock display: seconds, minutes and hours as six BCD digits, advanced by a 1-cycle `increase` tick from the prescaler.
- Parametrised successor of the per-digit counters. One block holds the full digit cascade.
- Adds a selectable 12/24-hour mode, parallel time load with validity checking, per-field set buttons and a day rollover pulse.
- Sits between the 1 Hz tick generator and the 7-segment scan driver.

Parameters:
- HOUR_MODE, 24, hour format; legal values 24 (00–23) or 12 (12,01–11 with PM flag); any other value is a synthesis error.
- RST_PM, 0, PM flag value after reset; used in 12-hour mode only.

Ports:
- clk_out  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- increase  in  1  advance time by one second; single-cycle pulse.
- load  in  1  load load_value / load_pm when valid.
- load_value  in  24  BCD {h1,h0,m1,m0,s1,s0}, 4 bits per digit, h1 in MSBs.
- load_pm  in  1  PM flag loaded in 12-hour mode; ignored in 24-hour mode.
- inc_min  in  1  set button: minutes +1, wrapping within the field.
- inc_hour  in  1  set button: hours +1, wrapping within the field.
- alarm_set  in  1  latch alarm time (see Optional Feature).
- value  out  24  current time, same digit packing as load_value.
- pm  out  1  PM flag; constant 0 in 24-hour mode.
- day_over  out  1  one-cycle pulse on day rollover.
- load_err  out  1  one-cycle pulse when a load is rejected.
- alarm  out  1  alarm pulse (see Optional Feature).

Behaviour:
- Reset values:
  - 24-hour mode: value = 00:00:00 (24'h000000), pm = 0.
  - 12-hour mode: value = 12:00:00 (24'h120000), pm = RST_PM.
  - day_over, load_err and alarm = 0 in both modes.
- Priority per cycle: rst > load > (inc_hour | inc_min) > increase. Lower-priority inputs are ignored in that cycle, not queued.
- increase: registered, 1-cycle latency. Units digits count 0–9; tens of sec/min count 0–5. Carries ripple within the same cycle.
  - 24-hour: 23:59:59 -> 00:00:00, and day_over = 1 in the cycle the wrapped value is first visible.
  - 12-hour: 11:59:59 -> 12:00:00 with pm toggled; day_over pulses only on the PM->AM transition. 12:59:59 -> 01:00:00 with pm unchanged.
- inc_min: 59 -> 00. Seconds unchanged, no carry into hours.
- inc_hour: 23 -> 00 (24-hour) or 12 -> 01 (12-hour). inc_hour does not toggle pm and does not raise day_over.
- inc_min and inc_hour together: both fields step in the same cycle.
- load validity:
  - Every digit ≤ 9; s1 ≤ 5; m1 ≤ 5.
  - Hour 00–23 in 24-hour mode; 01–12 in 12-hour mode.
  - Valid: value and pm update next cycle.
  - Invalid: state unchanged, load_err = 1 for one cycle.
  - A load never raises day_over.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Internal state always holds a legal time. No illegal BCD state is reachable.

Optional Feature:
- Macro: BCD_HMS_ALARM_EN.
- Defined:
  - alarm_set latches load_value[23:8] (hh:mm) and load_pm into alarm registers. It uses the same validity check as load, with load_err on reject.
  - Alarm registers reset to the reset time.
  - alarm = 1 for one cycle when an increase step makes value equal hh:mm:00, including pm in 12-hour mode.
  - Matches created by load or set buttons do not fire.
- Undefined: no alarm registers; alarm tied 0; alarm_set ignored. The port list is identical in both builds.

Test Plan:
- Reset, 24-hour mode: rst = 1 then 0 -> value = 24'h000000, pm = 0; 61 increase pulses -> 24'h000101.
- 24-hour rollover: load 24'h235959, then increase -> value = 24'h000000 and day_over high exactly one cycle.
- 12-hour sequence: load 24'h115959 with load_pm = 1, then increase -> 24'h120000, pm = 0, day_over = 1. Load 24'h125959 with pm = 0, then increase -> 24'h010000, pm = 0, no day_over.
- Load checks: load 24'h246000 in 24-hour mode -> load_err pulse, value unchanged. Load 24'h000000 in 12-hour mode -> load_err pulse.
- Set buttons: at 24'h105930, inc_min + inc_hour + increase in the same cycle -> 24'h110030. At 24'h235900, inc_hour -> 24'h005900.
- Alarm (BCD_HMS_ALARM_EN): alarm_set with 24'h0700xx, load 24'h065959, then increase -> alarm pulse one cycle at 24'h070000. Load 24'h070000 directly -> no pulse.
